// File: rtl/bin_to_bcd16_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd16_if
//  Brief    : Request/result bundle for the 16-bit binary-to-BCD converter.
//  Revision : 1.0
// ============================================================================
interface bin_to_bcd16_if;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd16.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd16
//  Brief    : Sequential double-dabble converter, 16-bit binary to 4 BCD
//             digits, saturating at 9999 with overflow flag.
//             Optional macro BIN2BCD_AUTO_EN: auto-convert on operand change.
//  Revision : 1.0
// ============================================================================
module bin_to_bcd16 (
    input  wire                 clk,
    input  wire                 rst,
    bin_to_bcd16_if.slave       bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]  r_state;
    logic [15:0] r_shift;
    logic [19:0] r_scratch;
    logic [3:0]  r_cnt;
    logic [15:0] r_bcd;
    logic        r_ovf;
    logic        r_done;
    logic        r_busy;
    logic        w_go;
    logic [19:0] w_adj;
    logic [35:0] w_shl;

    for (genvar g = 0; g < 5; g++) begin : g_digit
        assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                 r_scratch[4*g +: 4] + 4'd3 :
                                 r_scratch[4*g +: 4];
    end

    assign w_shl = {w_adj, r_shift} << 1;

`ifdef BIN2BCD_AUTO_EN
    logic [15:0] r_last;
    logic        r_last_vld;

    assign w_go = bus.start | ~r_last_vld | (bus.bin != r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= 16'h0000;
            r_last_vld <= 1'b0;
        end else if (r_state == S_IDLE && w_go) begin
            r_last     <= bus.bin;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_go = bus.start;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= 16'h0000;
            r_scratch <= 20'h00000;
            r_cnt     <= 4'd0;
            r_bcd     <= 16'h0000;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_shift   <= bus.bin;
                        r_scratch <= 20'h00000;
                        r_cnt     <= 4'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_shl[35:16];
                    r_shift   <= w_shl[15:0];
                    r_cnt     <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // Ten-thousands digit set means the operand exceeded 9999
                    if (r_scratch[19:16] != 4'd0) begin
                        r_bcd <= 16'h9999;
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= r_scratch[15:0];
                        r_ovf <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd16
//  Brief    : Scoreboard bench for bin_to_bcd16 with directed vectors.
//  Revision : 1.0
// ============================================================================
module tb_bin_to_bcd16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [16:0] exp_q[$];

    bin_to_bcd16_if bus ();

    bin_to_bcd16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges from the next one until done is seen; returns that edge count
    task automatic wait_done(input string name, output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) break;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for done got 0 expected 1", name);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("result", {15'd0, bus.bcd, bus.ovf}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n;
        int hits;
        int edges[3];
        logic [15:0] vin[4];
        logic [16:0] vexp[4];

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.bin = 16'd0;
`ifdef BIN2BCD_AUTO_EN
        bus.bin = 16'd500;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bcd", {16'd0, bus.bcd}, 32'h0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back({16'h0500, 1'b0});
        rst = 1'b0;
        wait_done("auto_first", n);
        check("auto_first_lat", n, 32'd18);
        bus.bin = 16'd501;
        exp_q.push_back({16'h0501, 1'b0});
        wait_done("auto_second", n);
        check("auto_second_lat", n, 32'd18);
        repeat (40) @(posedge clk);
        #1;
        check("auto_quiet_queue", exp_q.size(), 32'd0);
`else
        repeat (2) @(posedge clk);
        #1;
        check("reset_bcd", {16'd0, bus.bcd}, 32'h0);
        check("reset_ovf", {31'd0, bus.ovf}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic conversion with latency and busy/done timing
        bus.bin = 16'd1234;
        bus.start = 1'b1;
        exp_q.push_back({16'h1234, 1'b0});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_e0", {31'd0, bus.busy}, 32'd1);
        wait_done("t1234", n);
        check("latency_1234", n, 32'd17);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);

        // Boundary values
        vin[0] = 16'd0;     vexp[0] = {16'h0000, 1'b0};
        vin[1] = 16'd9999;  vexp[1] = {16'h9999, 1'b0};
        vin[2] = 16'd10000; vexp[2] = {16'h9999, 1'b1};
        vin[3] = 16'd65535; vexp[3] = {16'h9999, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.bin = vin[i];
            bus.start = 1'b1;
            exp_q.push_back(vexp[i]);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            wait_done("boundary", n);
            check("boundary_lat", n, 32'd17);
        end

        // Mid-conversion operand change and ignored start
        bus.bin = 16'd42;
        bus.start = 1'b1;
        exp_q.push_back({16'h0042, 1'b0});
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.bin = 16'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.bin = 16'd7777;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore_start", n);
        check("ignore_start_lat", n, 32'd12);
        repeat (25) @(posedge clk);
        #1;
        check("no_second_conv", exp_q.size(), 32'd0);

        // Start held high: back-to-back every 18 cycles
        bus.bin = 16'd8;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back({16'h0008, 1'b0});
        hits = 0;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 53; e++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (hits < 3) edges[hits] = e;
                hits++;
            end
            if (e == 53) bus.start = 1'b0;
        end
        check("held_count", hits, 32'd3);
        check("held_e1", edges[0], 32'd17);
        check("held_e2", edges[1], 32'd35);
        check("held_e3", edges[2], 32'd53);
        repeat (20) @(posedge clk);
        #1;
        check("held_stop", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset mid-conversion
        bus.bin = 16'd321;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_bcd", {16'd0, bus.bcd}, 32'h0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("abort_idle", {31'd0, bus.busy}, 32'd0);
        check("abort_queue", exp_q.size(), 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
